// File: rtl/lc4_div_iter_pkg.sv
// Shared LC4 divider definitions: state encodings, iteration count and a
// gate-level counter increment so the cla16 stays the only adder in the block.
package lc4_div_iter_pkg;

    localparam int LC4_DIV_W     = 16;
    localparam int LC4_DIV_ITERS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic [3:0] inc4(input logic [3:0] v);
        inc4 = {v[3] ^ (&v[2:0]), v[2] ^ (&v[1:0]), v[1] ^ v[0], ~v[0]};
    endfunction

endpackage

// File: rtl/lc4_div_iter_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with lookahead across groups.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    logic [15:0] g, p, c;
    logic [3:0]  gg, gp, cg;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        cg = '0;
        c  = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
                    (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        cg[0] = cin;
        cg[1] = gg[0] | (gp[0] & cin);
        cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = cg[j];
            c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                       (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/lc4_div_iter.sv
// Iterative restoring divider for LC4 DIV/MOD: one quotient bit per cycle,
// trial subtraction through a single cla16.
module lc4_div_iter
    import lc4_div_iter_pkg::*;
#(
    parameter int W     = LC4_DIV_W,
    parameter int ITERS = LC4_DIV_ITERS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_valid,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);

    div_state_e   state, state_nxt;
    logic [3:0]   count;
    logic [W-1:0] rem, q, dvs;
    logic         div0;

    logic         accept;
    logic [W:0]   rem_sh;
    logic [W-1:0] diff;
    logic         a15, b15, cout, geq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: if (i_start) begin
                accept    = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: if (count == 4'(ITERS-1)) state_nxt = ST_DONE;
            ST_DONE: begin
                accept    = i_start;
                state_nxt = i_start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Trial subtraction rem_sh - div as rem_sh + ~div + 1; the carry out of bit 15
    // is rebuilt from the sum bit since cla16 exposes no carry port.
    assign rem_sh = {rem, q[W-1]};

    cla16 u_cla (
        .a   (rem_sh[W-1:0]),
        .b   (~dvs),
        .cin (1'b1),
        .sum (diff)
    );

    assign a15  = rem_sh[W-1];
    assign b15  = ~dvs[W-1];
    assign cout = (a15 & b15) | ((a15 | b15) & (diff[W-1] ^ a15 ^ b15));
    assign geq  = rem_sh[W] | cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            q     <= '0;
            dvs   <= '0;
            div0  <= 1'b0;
            count <= '0;
        end else if (accept) begin
            rem   <= '0;
            q     <= i_dividend;
            dvs   <= i_divisor;
            div0  <= (i_divisor == '0);
            count <= '0;
        end else if (state == ST_RUN) begin
            rem   <= geq ? diff : rem_sh[W-1:0];
            q     <= {q[W-2:0], geq};
            count <= inc4(count);
        end
    end

    // Divide-by-zero reports 0/0 regardless of what the iterations produced.
    assign o_busy      = (state == ST_RUN);
    assign o_valid     = (state == ST_DONE);
    assign o_quotient  = div0 ? '0 : q;
    assign o_remainder = div0 ? '0 : rem;

endmodule

// File: tb/tb_lc4_div_iter.sv
// Directed and randomized checks for lc4_div_iter: latency, corner quotients,
// divide-by-zero, ignored starts, back-to-back issue and mid-run reset.
module tb_lc4_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [15:0] i_dividend, i_divisor;
    logic        o_busy, o_valid;
    logic [15:0] o_quotient, o_remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc4_div_iter dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Counts edges after the accept edge until valid, and busy samples on the way.
    task automatic wait_valid(output int lat, output int bcnt);
        lat  = 0;
        bcnt = (o_busy === 1'b1) ? 1 : 0;
        while (o_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (o_busy === 1'b1) bcnt++;
        end
    endtask

    task automatic div_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r,
                          output int lat, output int bcnt);
        start_op(a, b);
        wait_valid(lat, bcnt);
        q = o_quotient;
        r = o_remainder;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
        #2;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_quotient !== 16'd0 || o_remainder !== 16'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b q=%h r=%h want 0 0 0000 0000",
                     o_busy, o_valid, o_quotient, o_remainder);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] q, r;
        int lat, bcnt;
        div_op(16'd100, 16'd7, q, r, lat, bcnt);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", lat); end
        checks++;
        if (bcnt !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d want 16", bcnt); end
        checks++;
        if (q !== 16'd14 || r !== 16'd2) begin errors++; $display("FAIL basic_100_7 got q=%0d r=%0d want q=14 r=2", q, r); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_valid got %b want 0", o_busy); end
        step();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width got %b want 0", o_valid); end
        repeat (3) step();
        checks++;
        if (o_quotient !== 16'd14 || o_remainder !== 16'd2) begin
            errors++; $display("FAIL basic_hold got q=%0d r=%0d want q=14 r=2", o_quotient, o_remainder);
        end
    endtask

    task automatic test_corners();
        logic [15:0] q, r;
        int lat, bcnt;
        div_op(16'hFFFF, 16'h0001, q, r, lat, bcnt); step();
        checks++;
        if (q !== 16'hFFFF || r !== 16'h0000) begin errors++; $display("FAIL ffff_1 got q=%h r=%h want q=ffff r=0000", q, r); end
        div_op(16'hFFFF, 16'hFFFF, q, r, lat, bcnt); step();
        checks++;
        if (q !== 16'h0001 || r !== 16'h0000) begin errors++; $display("FAIL ffff_ffff got q=%h r=%h want q=0001 r=0000", q, r); end
        div_op(16'h8000, 16'hFFFF, q, r, lat, bcnt); step();
        checks++;
        if (q !== 16'h0000 || r !== 16'h8000) begin errors++; $display("FAIL 8000_ffff got q=%h r=%h want q=0000 r=8000", q, r); end
        div_op(16'hFFFE, 16'h8000, q, r, lat, bcnt); step();
        checks++;
        if (q !== 16'h0001 || r !== 16'h7FFE) begin errors++; $display("FAIL fffe_8000 got q=%h r=%h want q=0001 r=7ffe", q, r); end
    endtask

    task automatic test_div0();
        logic [15:0] q, r;
        int lat, bcnt;
        div_op(16'd1234, 16'd0, q, r, lat, bcnt);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL div0_latency got %0d want 16", lat); end
        checks++;
        if (q !== 16'd0 || r !== 16'd0) begin errors++; $display("FAIL div0_result got q=%0d r=%0d want q=0 r=0", q, r); end
        step();
        div_op(16'd0, 16'd5, q, r, lat, bcnt); step();
        checks++;
        if (q !== 16'd0 || r !== 16'd0) begin errors++; $display("FAIL zero_dividend got q=%0d r=%0d want q=0 r=0", q, r); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        start_op(16'd50, 16'd3);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 40) begin
            if (lat == 5) begin i_start = 1'b1; i_dividend = 16'd20; i_divisor = 16'd4; end
            else i_start = 1'b0;
            step();
            lat++;
        end
        i_start = 1'b0;
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL ignore_latency got %0d want 16", lat); end
        checks++;
        if (o_quotient !== 16'd16 || o_remainder !== 16'd2) begin
            errors++; $display("FAIL ignore_start got q=%0d r=%0d want q=16 r=2", o_quotient, o_remainder);
        end
        start_op(16'd20, 16'd4);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept got valid=%b busy=%b want 0 1", o_valid, o_busy);
        end
        wait_valid(lat, bcnt);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL b2b_latency got %0d want 16", lat); end
        checks++;
        if (o_quotient !== 16'd5 || o_remainder !== 16'd0) begin
            errors++; $display("FAIL b2b_result got q=%0d r=%0d want q=5 r=0", o_quotient, o_remainder);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [15:0] q, r;
        int lat, bcnt, pulses;
        start_op(16'd1000, 16'd3);
        repeat (8) step();
        rst = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_quotient !== 16'd0 || o_remainder !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_async busy=%b valid=%b q=%h r=%h want 0 0 0000 0000",
                     o_busy, o_valid, o_quotient, o_remainder);
        end
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) rst = 1'b0;
            step();
            if (o_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL reset_mid_no_valid got %0d pulses want 0", pulses); end
        div_op(16'd9, 16'd2, q, r, lat, bcnt); step();
        checks++;
        if (q !== 16'd4 || r !== 16'd1 || lat !== 16) begin
            errors++; $display("FAIL after_reset_9_2 got q=%0d r=%0d lat=%0d want q=4 r=1 lat=16", q, r, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, q, r, eq, er;
        int lat, bcnt;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            case (i % 4)
                0: b = 16'($urandom_range(0, 15));
                1: b = 16'($urandom_range(0, 255));
                default: b = 16'($urandom);
            endcase
            eq = (b == 16'd0) ? 16'd0 : a / b;
            er = (b == 16'd0) ? 16'd0 : a % b;
            div_op(a, b, q, r, lat, bcnt);
            checks++;
            if (q !== eq || r !== er || lat !== 16) begin
                errors++;
                $display("FAIL random %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=16",
                         a, b, q, r, lat, eq, er);
            end
            step();
            checks++;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL random_valid_width got %b want 0", o_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
